// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Single-outstanding load/store controller driving the data-memory
//            port, with alignment checking, ack timeout and load formatting.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        data_ce_o,
    output logic        data_we_o,
    output logic [3:0]  data_sel_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    input  logic        data_rvalid_i,
    input  logic        data_wack_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic [4:0]  rsp_rd_o,
    output logic        rsp_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           we_q, we_d;
    logic [1:0]     size_q, size_d;
    logic           uns_q, uns_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [4:0]     rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic [4:0]     rsp_rd_q, rsp_rd_d;
    logic           rsp_err_q, rsp_err_d;

    logic           w_misaligned;
    logic           w_ack;
    logic [1:0]     w_off;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_load;
    logic           w_access;

    assign w_off    = addr_q[1:0];
    assign w_access = (state_q == ACCESS);

    assign w_misaligned = (req_size_i == 2'b11) ||
                          (req_size_i == 2'b01 && req_addr_i[0]) ||
                          (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

    // Only the acknowledge that matches the operation type completes it.
    assign w_ack  = we_q ? data_wack_i : data_rvalid_i;
    assign w_byte = data_rdata_i[{w_off, 3'b000} +: 8];
    assign w_half = data_rdata_i[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load = data_rdata_i;
        case (size_q)
            2'b00:   w_load = uns_q ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = uns_q ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = data_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        rsp_rdata_d = 32'h0;
        rsp_rd_d    = 5'h0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    rd_d    = req_rd_i;
                    cnt_d   = CW'(1);
                    if (w_misaligned) begin
                        state_d   = RESP;
                        rsp_err_d = 1'b1;
                        rsp_rd_d  = req_rd_i;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle still completes normally.
                if (w_ack) begin
                    state_d     = RESP;
                    rsp_rd_d    = rd_q;
                    rsp_rdata_d = we_q ? 32'h0 : w_load;
                end else if (cnt_q == C_TMAX) begin
                    state_d   = RESP;
                    rsp_rd_d  = rd_q;
                    rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rd_q        <= 5'h0;
            cnt_q       <= '0;
            rsp_rdata_q <= 32'h0;
            rsp_rd_q    <= 5'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_rdata_o  = rsp_rdata_q;
    assign rsp_rd_o     = rsp_rd_q;
    assign rsp_err_o    = rsp_err_q;

    assign data_ce_o    = w_access;
    assign data_we_o    = w_access & we_q;
    assign data_addr_o  = w_access ? {addr_q[31:2], 2'b00} : 32'h0;

    always_comb begin
        data_sel_o   = 4'h0;
        data_wdata_o = 32'h0;
        if (w_access) begin
            case (size_q)
                2'b00: begin
                    data_sel_o   = 4'b0001 << w_off;
                    data_wdata_o = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    data_sel_o   = 4'b0011 << w_off;
                    data_wdata_o = {2{wdata_q[15:0]}};
                end
                default: begin
                    data_sel_o   = 4'b1111;
                    data_wdata_o = wdata_q;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Brief    : Directed self-checking bench for lsu_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic [4:0]  req_rd_i = 5'h0;
    logic        data_ce_o;
    logic        data_we_o;
    logic [3:0]  data_sel_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i = 32'h0;
    logic        data_rvalid_i = 1'b0;
    logic        data_wack_i = 1'b0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic [4:0]  rsp_rd_o;
    logic        rsp_err_o;

    int checks = 0;
    int failures = 0;

    lsu_ctrl #(.TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .data_ce_o(data_ce_o), .data_we_o(data_we_o),
        .data_sel_o(data_sel_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
        .data_rvalid_i(data_rvalid_i), .data_wack_i(data_wack_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_rd_o(rsp_rd_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        req_valid_i = 1'b1; req_we_i = we; req_size_i = sz; req_unsigned_i = uns;
        req_addr_i = a; req_wdata_i = wd; req_rd_i = rd;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        checks++; if ({data_ce_o, data_we_o, data_sel_o, data_addr_o, data_wdata_o} !== 70'h0) begin failures++; $display("FAIL reset_data got ce=%b sel=%h addr=%h exp all 0", data_ce_o, data_sel_o, data_addr_o); end
        checks++; if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_rd_o} !== 39'h0) begin failures++; $display("FAIL reset_rsp got v=%b e=%b d=%h rd=%h exp 0", rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_rd_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_store_byte();
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00AB, 5'd5);
        tick();
        req_valid_i = 1'b0;
        checks++; if ({data_ce_o, data_we_o, data_sel_o} !== 6'b11_0100) begin failures++; $display("FAIL sb_ctrl got ce=%b we=%b sel=%b exp 1 1 0100", data_ce_o, data_we_o, data_sel_o); end
        checks++; if (data_addr_o !== 32'h0000_0004) begin failures++; $display("FAIL sb_addr got=%h exp=00000004", data_addr_o); end
        checks++; if (data_wdata_o !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=ababab ab", data_wdata_o); end
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL sb_ready_busy got=%b exp=0", req_ready_o); end
        data_wack_i = 1'b1;
        tick();
        data_wack_i = 1'b0;
        checks++; if ({rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o} !== {1'b1, 1'b0, 5'd5, 32'h0}) begin failures++; $display("FAIL sb_rsp got v=%b e=%b rd=%0d d=%h exp 1 0 5 0", rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o); end
        checks++; if (data_ce_o !== 1'b0) begin failures++; $display("FAIL sb_ce_after got=%b exp=0", data_ce_o); end
        tick();
        checks++; if ({rsp_valid_o, req_ready_o, rsp_rd_o} !== {1'b0, 1'b1, 5'd0}) begin failures++; $display("FAIL sb_idle got v=%b rdy=%b rd=%0d exp 0 1 0", rsp_valid_o, req_ready_o, rsp_rd_o); end
    endtask

    task automatic test_load_format();
        logic [31:0] addrs [3] = '{32'h0000_0012, 32'h0000_0012, 32'h0000_0021};
        logic [1:0]  szs   [3] = '{2'b01, 2'b01, 2'b00};
        logic        unss  [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] rds   [3] = '{32'h8001_1234, 32'h8001_1234, 32'h1234_80FF};
        logic [3:0]  sels  [3] = '{4'b1100, 4'b1100, 4'b0010};
        logic [31:0] exps  [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, szs[i], unss[i], addrs[i], 32'hFFFF_FFFF, 5'(i + 7));
            tick();
            req_valid_i = 1'b0;
            checks++; if ({data_ce_o, data_we_o, data_sel_o} !== {2'b10, sels[i]}) begin failures++; $display("FAIL ld%0d_ctrl got ce=%b we=%b sel=%b exp 1 0 %b", i, data_ce_o, data_we_o, data_sel_o, sels[i]); end
            data_rvalid_i = 1'b1; data_rdata_i = rds[i];
            tick();
            data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
            checks++; if ({rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o} !== {2'b10, 5'(i + 7), exps[i]}) begin failures++; $display("FAIL ld%0d_rsp got v=%b e=%b rd=%0d d=%h exp 1 0 %0d %h", i, rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o, i + 7, exps[i]); end
            tick();
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  szs [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] as  [3] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0003};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, szs[i], 1'b0, as[i], 32'h0, 5'd9);
            tick();
            req_valid_i = 1'b0;
            data_rvalid_i = 1'b1; data_rdata_i = 32'h5555_5555;
            checks++; if ({data_ce_o, rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o} !== {3'b011, 5'd9, 32'h0}) begin failures++; $display("FAIL mis%0d got ce=%b v=%b e=%b rd=%0d d=%h exp 0 1 1 9 0", i, data_ce_o, rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o); end
            tick();
            data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
            checks++; if ({req_ready_o, rsp_valid_o, rsp_err_o} !== 3'b100) begin failures++; $display("FAIL mis%0d_after got rdy=%b v=%b e=%b exp 1 0 0", i, req_ready_o, rsp_valid_o, rsp_err_o); end
        end
    endtask

    task automatic test_wait_states();
        int bad = 0;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd3);
        tick();
        req_valid_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (!(data_ce_o === 1'b1 && data_addr_o === 32'h100 && data_sel_o === 4'hF && rsp_valid_o === 1'b0)) bad++;
            data_wack_i   = (c == 2);
            data_rvalid_i = (c == 4);
            data_rdata_i  = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
            tick();
        end
        data_wack_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL wait_hold got bad_cycles=%0d exp=0", bad); end
        checks++; if ({rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o} !== {2'b10, 5'd3, 32'hDEAD_BEEF}) begin failures++; $display("FAIL wait_rsp got v=%b e=%b rd=%0d d=%h exp 1 0 3 deadbeef", rsp_valid_o, rsp_err_o, rsp_rd_o, rsp_rdata_o); end
        tick();
    endtask

    task automatic test_timeout(input logic ack_last);
        int ce_cycles = 0;
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_CDEF, 5'd17);
        tick();
        req_valid_i = 1'b0;
        checks++; if ({data_sel_o, data_wdata_o} !== {4'b1100, 32'hCDEF_CDEF}) begin failures++; $display("FAIL to%0b_lanes got sel=%b wd=%h exp 1100 cdefcdef", ack_last, data_sel_o, data_wdata_o); end
        for (int c = 1; c <= 16; c++) begin
            if (data_ce_o === 1'b1 && rsp_valid_o === 1'b0) ce_cycles++;
            data_rvalid_i = (c == 5);
            data_wack_i   = ack_last && (c == 16);
            tick();
        end
        data_rvalid_i = 1'b0; data_wack_i = 1'b0;
        checks++; if (ce_cycles !== 16) begin failures++; $display("FAIL to%0b_cycles got=%0d exp=16", ack_last, ce_cycles); end
        checks++; if ({rsp_valid_o, rsp_err_o, rsp_rd_o, data_ce_o} !== {1'b1, ~ack_last, 5'd17, 1'b0}) begin failures++; $display("FAIL to%0b_rsp got v=%b e=%b rd=%0d ce=%b exp 1 %b 17 0", ack_last, rsp_valid_o, rsp_err_o, rsp_rd_o, data_ce_o, ~ack_last); end
        tick();
    endtask

    task automatic test_reset_mid_access();
        int seen = 0;
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 5'd21);
        tick();
        req_valid_i = 1'b0;
        tick();
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({data_ce_o, data_addr_o, req_ready_o} !== {1'b0, 32'h0, 1'b1}) begin failures++; $display("FAIL rstmid_now got ce=%b addr=%h rdy=%b exp 0 0 1", data_ce_o, data_addr_o, req_ready_o); end
        tick();
        rst_ni = 1'b1;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h1111_1111;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid_o !== 1'b0 || data_ce_o !== 1'b0) seen++;
            tick();
        end
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        checks++; if ({seen, req_ready_o} !== {32'd0, 1'b1}) begin failures++; $display("FAIL rstmid_after got spurious=%0d rdy=%b exp 0 1", seen, req_ready_o); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 5'd1);
        tick();
        req_valid_i = 1'b0; data_wack_i = 1'b1;
        tick();
        data_wack_i = 1'b0;
        tick();
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready_o); end
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0043, 32'h0, 5'd2);
        tick();
        req_valid_i = 1'b0;
        checks++; if ({data_ce_o, data_we_o, data_sel_o, data_addr_o} !== {2'b10, 4'b1000, 32'h40}) begin failures++; $display("FAIL b2b_ctrl got ce=%b we=%b sel=%b a=%h exp 1 0 1000 40", data_ce_o, data_we_o, data_sel_o, data_addr_o); end
        data_rvalid_i = 1'b1; data_rdata_i = 32'h9A00_0000;
        tick();
        data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        checks++; if ({rsp_valid_o, rsp_rd_o, rsp_rdata_o} !== {1'b1, 5'd2, 32'h0000_009A}) begin failures++; $display("FAIL b2b_rsp got v=%b rd=%0d d=%h exp 1 2 0000009a", rsp_valid_o, rsp_rd_o, rsp_rdata_o); end
        tick();
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_format();
        test_misaligned();
        test_wait_states();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller for the milano core: accepts one memory operation at a time from the execute stage and drives the data-memory port as its initiator. It generates chip-enable, write-enable, byte selects, word address and lane-replicated store data, then waits for the memory's read-valid or write-acknowledge. It returns a formatted, sign- or zero-extended load result, with a destination tag, to writeback. Misaligned accesses and unanswered accesses are reported as errors instead of hanging the pipeline.

## Interface
- TIMEOUT, 16: maximum number of cycles spent in ACCESS waiting for the memory acknowledge (>=1).
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  execute stage presents an operation.
- req_ready_o  out  1  controller can accept; equals (state==IDLE).
- req_we_i  in  1  1=store, 0=load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  zero-extend load (ignored for word/store).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- req_rd_i  in  5  destination register tag.
- data_ce_o  out  1  memory chip enable.
- data_we_o  out  1  memory write enable.
- data_sel_o  out  4  byte selects.
- data_addr_o  out  32  word-aligned address, {addr[31:2],2'b00}.
- data_wdata_o  out  32  lane-replicated store data.
- data_rdata_i  in  32  memory read data.
- data_rvalid_i  in  1  read data valid.
- data_wack_i  in  1  write completed.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  32  formatted load data; 0 for stores and errors.
- rsp_rd_o  out  5  latched tag of the completed operation.
- rsp_err_o  out  1  misaligned, illegal size, or timeout.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on req_valid_i, latch we/size/unsigned/addr/wdata/rd.
  - If misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 11), go to RESP with error set; no memory access is issued.
  - Otherwise go to ACCESS.
- ACCESS: data_ce_o=1; data_we_o, data_sel_o, data_addr_o and data_wdata_o are driven from latched values and held stable every cycle of ACCESS.
  - Load completes on data_rvalid_i. Capture and format data_rdata_i, then go to RESP.
  - Store completes on data_wack_i. Go to RESP.
  - Only the matching acknowledge counts: data_wack_i during a load and data_rvalid_i during a store are ignored.
  - Wait counter starts at 1 on ACCESS entry. If the TIMEOUT-th ACCESS cycle ends without a matching acknowledge, go to RESP with error. An acknowledge on that same cycle wins, so no error is raised.
- RESP: rsp_valid_o=1 for exactly one cycle with the latched rd and the error flag, then return to IDLE.
- Outside ACCESS: data_ce_o, data_we_o, data_sel_o, data_addr_o and data_wdata_o are all 0.
- Acknowledges arriving in IDLE or RESP are ignored.
- Byte selects, with off=addr[1:0]: byte 4'b0001<<off; half 4'b0011<<off; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load format:
  - Byte: rdata[8*off+:8].
  - Half: rdata[16*off[1]+:16].
  - Word: rdata unchanged.
  - Byte and half are sign-extended unless req_unsigned_i=1, in which case they are zero-extended.
- Reset (asserted at any time, including mid-ACCESS): state forced to IDLE. The in-flight operation is dropped, with no response.

## Timing
- Reset values: all data_* outputs 0; rsp_valid_o, rsp_err_o, rsp_rdata_o, rsp_rd_o 0; req_ready_o 1.
- Accept at edge 0. ACCESS during cycle 1. With the acknowledge in cycle 1, rsp_valid_o is high in cycle 2 and req_ready_o is high again in cycle 3.
- Best-case throughput: one operation every 3 cycles.
- Each additional wait cycle in ACCESS adds 1 cycle of latency.
- Misaligned request: accepted at edge 0, rsp_valid_o high in cycle 1 with rsp_err_o=1.
- Timeout response: rsp_valid_o high in cycle TIMEOUT+1.
- rsp_* outputs are registered; rsp_rdata_o, rsp_rd_o and rsp_err_o are valid only while rsp_valid_o=1 and are 0 otherwise.

## Test plan
- Store byte, addr 0x0000_0006, wdata 0x0000_00AB, wack in cycle 1 -> ce=1, we=1, sel=4'b0100, addr=0x0000_0004, wdata=0xABAB_ABAB for one cycle; rsp_valid in cycle 2 with err=0.
- Load signed half, addr 0x0000_0012, rdata 0x8001_1234, rvalid in cycle 1 -> sel=4'b1100, rsp_rdata=0xFFFF_8001. Same with unsigned -> 0x0000_8001.
- Load word, addr 0x0000_0002 -> no ce pulse; rsp_valid in cycle 1 with err=1, rdata=0. Size 11 -> same response.
- Load with rvalid delayed 3 cycles -> address and sel held stable for 4 ACCESS cycles; response one cycle after rvalid. Also: wack during a load -> ignored.
- Store with TIMEOUT=16 and no wack -> 16 ACCESS cycles, then rsp_err=1. Repeat with wack on cycle 16 -> err=0.
- Assert rst_ni low during the 2nd ACCESS cycle -> outputs zero immediately, no rsp_valid after release, req_ready=1.
